sd_spi_init_ctrl: RTL and testbench

SD-card initialization sequencer sitting above the SPI byte engine in the peripheral subsystem. It issues the SPI-mode power-up and initialization sequence (dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop, CMD58) one byte at a time through a start/done handshake. It reports card readiness, version and capacity class. After init it hands the engine back at full speed with the card deselected.

---
 rtl/sd_init_pkg.sv | 36 +++
 rtl/sd_cmd_framer.sv | 33 +++
 rtl/sd_spi_init_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_sd_spi_init_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_init_pkg.sv
// Shared definitions for the SD-card SPI-mode initialization sequencer.
// States, command indices, CRC bytes, error codes and divider encodings.
package sd_init_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_CMD,
        S_POLL,
        S_TAIL,
        S_GAP,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD58  = 6'd58;

    localparam logic [7:0] CRC_CMD0 = 8'h95;
    localparam logic [7:0] CRC_CMD8 = 8'h87;
    localparam logic [7:0] CRC_NONE = 8'h01;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_CMD0   = 3'd1;
    localparam logic [2:0] ERR_CMD8   = 3'd2;
    localparam logic [2:0] ERR_ACMD41 = 3'd3;
    localparam logic [2:0] ERR_CMD58  = 3'd4;
    localparam logic [2:0] ERR_POLL   = 3'd5;

    localparam logic [2:0] DIV_SLOW = 3'b100;
    localparam logic [2:0] DIV_FAST = 3'b000;

endpackage

// File: rtl/sd_cmd_framer.sv
// Combinational SD command frame generator.
// Returns byte idx_i of the 6-byte frame for command cmd_i.
module sd_cmd_framer
    import sd_init_pkg::*;
(
    input  logic [5:0] cmd_i,
    input  logic       hcs_i,
    input  logic [2:0] idx_i,
    output logic [7:0] byte_o
);

    logic [7:0] crc;

    always_comb begin
        crc = CRC_NONE;
        if (cmd_i == CMD0) begin
            crc = CRC_CMD0;
        end else if (cmd_i == CMD8) begin
            crc = CRC_CMD8;
        end
        byte_o = 8'hFF;
        unique case (idx_i)
            3'd0: byte_o = {2'b01, cmd_i};
            3'd1: byte_o = (cmd_i == ACMD41 && hcs_i) ? 8'h40 : 8'h00;
            3'd2: byte_o = 8'h00;
            3'd3: byte_o = (cmd_i == CMD8) ? 8'h01 : 8'h00;
            3'd4: byte_o = (cmd_i == CMD8) ? 8'hAA : 8'h00;
            3'd5: byte_o = crc;
            default: byte_o = 8'hFF;
        endcase
    end

endmodule

// File: rtl/sd_spi_init_ctrl.sv
// SD-card SPI-mode init sequencer driving a byte engine via start/done.
// Runs power-up clocks, CMD0, CMD8, CMD55/ACMD41 loop and CMD58.
module sd_spi_init_ctrl
    import sd_init_pkg::*;
#(
    parameter int unsigned RETRY_MAX = 1000,
    parameter int unsigned R1_POLL   = 8,
    parameter int unsigned PWR_BYTES = 10
) (
    input  logic       spi_clk_i,
    input  logic       spi_rst_ni,
    input  logic       start_i,
    output logic       busy_o,
    output logic       ready_o,
    output logic       err_o,
    output logic [2:0] err_code_o,
    output logic       card_v2_o,
    output logic       card_hc_o,
    output logic       cs_o,
    output logic [5:0] spi_statusreg_o,
    output logic       xfer_start_o,
    output logic [7:0] xfer_tx_o,
    input  logic       xfer_done_i,
    input  logic [7:0] xfer_rx_i
);

    localparam logic [3:0] PWR_LAST  = 4'(PWR_BYTES - 1);
    localparam logic [3:0] POLL_LAST = 4'(R1_POLL - 1);
    localparam logic [9:0] RETRY_LIM = 10'(RETRY_MAX);

    state_e      state_q, state_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        out_q, out_d;
    logic        xs_q;
    logic [7:0]  tx_q, tx_d;
    logic        cs_q, cs_d;
    logic [7:0]  r1_q, r1_d;
    logic [31:0] tail_q, tail_d;
    logic [9:0]  retry_q, retry_d, retry_inc;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [2:0]  code_q, code_d;
    logic        v2_q, v2_d;
    logic        hc_q, hc_d;

    logic        go, issue, fail, byte_done;
    logic [5:0]  ncmd;
    logic [2:0]  fcode;
    logic [7:0]  frame_b;
    logic        unused_tail;

    assign unused_tail = ^{tail_q[31], tail_q[29:24]};

    sd_cmd_framer u_framer (
        .cmd_i  (cmd_d),
        .hcs_i  (v2_d),
        .idx_i  (cnt_d[2:0]),
        .byte_o (frame_b)
    );

    assign byte_done = xfer_done_i & out_q;
    assign retry_inc = (retry_q == RETRY_LIM) ? retry_q : retry_q + 10'd1;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        tx_d    = tx_q;
        cs_d    = cs_q;
        r1_d    = r1_q;
        tail_d  = tail_q;
        retry_d = retry_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        err_d   = err_q;
        code_d  = code_q;
        v2_d    = v2_q;
        hc_d    = hc_q;
        go      = 1'b0;
        issue   = 1'b0;
        fail    = 1'b0;
        fcode   = ERR_NONE;
        ncmd    = cmd_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_PWRUP;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    out_d   = 1'b1;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    v2_d    = 1'b0;
                    hc_d    = 1'b0;
                    go      = 1'b1;
                end
            end
            S_PWRUP: begin
                if (byte_done) begin
                    go = 1'b1;
                    if (cnt_q == PWR_LAST) begin
                        issue = 1'b1;
                        ncmd  = CMD0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_CMD: begin
                if (byte_done) begin
                    go = 1'b1;
                    if (cnt_q == 4'd5) begin
                        state_d = S_POLL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_POLL: begin
                if (byte_done) begin
                    if (!xfer_rx_i[7]) begin
                        r1_d  = xfer_rx_i;
                        cnt_d = '0;
                        go    = 1'b1;
                        if (cmd_q == CMD8 || cmd_q == CMD58) begin
                            state_d = S_TAIL;
                        end else begin
                            state_d = S_GAP;
                            cs_d    = 1'b1;
                        end
                    end else if (cnt_q == POLL_LAST) begin
                        fail  = 1'b1;
                        fcode = ERR_POLL;
                    end else begin
                        go    = 1'b1;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_TAIL: begin
                if (byte_done) begin
                    go     = 1'b1;
                    tail_d = {tail_q[23:0], xfer_rx_i};
                    if (cnt_q == 4'd3) begin
                        state_d = S_GAP;
                        cs_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (byte_done) begin
                    unique case (1'b1)
                        (cmd_q == CMD0): begin
                            if (r1_q == 8'h01) begin
                                issue = 1'b1;
                                ncmd  = CMD8;
                            end else begin
                                fail  = 1'b1;
                                fcode = ERR_CMD0;
                            end
                        end
                        (cmd_q == CMD8): begin
                            if (r1_q == 8'h05) begin
                                v2_d  = 1'b0;
                                issue = 1'b1;
                                ncmd  = CMD55;
                            end else if (r1_q == 8'h01 && tail_q[11:0] == 12'h1AA) begin
                                v2_d  = 1'b1;
                                issue = 1'b1;
                                ncmd  = CMD55;
                            end else begin
                                fail  = 1'b1;
                                fcode = ERR_CMD8;
                            end
                        end
                        (cmd_q == CMD55): begin
                            if (!r1_q[2]) begin
                                issue = 1'b1;
                                ncmd  = ACMD41;
                            end else begin
                                fail  = 1'b1;
                                fcode = ERR_ACMD41;
                            end
                        end
                        (cmd_q == ACMD41): begin
                            if (r1_q == 8'h00) begin
                                issue = 1'b1;
                                ncmd  = CMD58;
                            end else if (r1_q == 8'h01) begin
                                retry_d = retry_inc;
                                if (retry_inc == RETRY_LIM) begin
                                    fail  = 1'b1;
                                    fcode = ERR_ACMD41;
                                end else begin
                                    issue = 1'b1;
                                    ncmd  = CMD55;
                                end
                            end else begin
                                fail  = 1'b1;
                                fcode = ERR_ACMD41;
                            end
                        end
                        (cmd_q == CMD58): begin
                            if (r1_q == 8'h00) begin
                                hc_d    = tail_q[30] & v2_q;
                                state_d = S_DONE;
                                ready_d = 1'b1;
                                busy_d  = 1'b0;
                                out_d   = 1'b0;
                            end else begin
                                fail  = 1'b1;
                                fcode = ERR_CMD58;
                            end
                        end
                        default: begin
                            fail  = 1'b1;
                            fcode = ERR_CMD0;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            state_d = S_CMD;
            cmd_d   = ncmd;
            cnt_d   = '0;
            cs_d    = 1'b0;
            go      = 1'b1;
        end
        if (fail) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = fcode;
            busy_d  = 1'b0;
            out_d   = 1'b0;
            cs_d    = 1'b1;
            go      = 1'b0;
        end
        if (go) begin
            tx_d = (state_d == S_CMD) ? frame_b : 8'hFF;
        end
    end

    always_ff @(posedge spi_clk_i or negedge spi_rst_ni) begin
        if (!spi_rst_ni) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            xs_q    <= 1'b0;
            tx_q    <= 8'hFF;
            cs_q    <= 1'b1;
            r1_q    <= 8'hFF;
            tail_q  <= '0;
            retry_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            v2_q    <= 1'b0;
            hc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            xs_q    <= go;
            tx_q    <= tx_d;
            cs_q    <= cs_d;
            r1_q    <= r1_d;
            tail_q  <= tail_d;
            retry_q <= retry_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            code_q  <= code_d;
            v2_q    <= v2_d;
            hc_q    <= hc_d;
        end
    end

    // Engine runs slow during init and is handed back fast only on success.
    assign spi_statusreg_o = {(state_q == S_DONE) ? DIV_FAST : DIV_SLOW,
                              2'b11, out_q};
    assign busy_o       = busy_q;
    assign ready_o      = ready_q;
    assign err_o        = err_q;
    assign err_code_o   = code_q;
    assign card_v2_o    = v2_q;
    assign card_hc_o    = hc_q;
    assign cs_o         = cs_q;
    assign xfer_start_o = xs_q;
    assign xfer_tx_o    = tx_q;

endmodule

// File: tb/tb_sd_spi_init_ctrl.sv
// Directed bench for sd_spi_init_ctrl with a byte-level SD card model.
// Each scenario selects the card's responses per command.
module tb_sd_spi_init_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       busy_o, ready_o, err_o, card_v2_o, card_hc_o, cs_o;
    logic [2:0] err_code_o;
    logic [5:0] spi_statusreg_o;
    logic       xfer_start_o;
    logic [7:0] xfer_tx_o;
    logic       xfer_done_i = 1'b0;
    logic [7:0] xfer_rx_i = 8'hFF;

    sd_spi_init_ctrl dut (
        .spi_clk_i       (clk),
        .spi_rst_ni      (rst_n),
        .start_i         (start_i),
        .busy_o          (busy_o),
        .ready_o         (ready_o),
        .err_o           (err_o),
        .err_code_o      (err_code_o),
        .card_v2_o       (card_v2_o),
        .card_hc_o       (card_hc_o),
        .cs_o            (cs_o),
        .spi_statusreg_o (spi_statusreg_o),
        .xfer_start_o    (xfer_start_o),
        .xfer_tx_o       (xfer_tx_o),
        .xfer_done_i     (xfer_done_i),
        .xfer_rx_i       (xfer_rx_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Card model state
    int         sc;
    int         nbytes, npwr, fcnt, npop, n_acmd, rst_starts;
    bit         seen_cs0, tail8;
    logic [5:0] mcmd;
    logic [7:0] acmd_arg;
    logic [7:0] q[$];

    task automatic load(input logic [5:0] c);
        q.delete();
        if (sc == 2) return;
        case (c)
            6'd0:  q = '{8'hFF, 8'h01};
            6'd8: begin
                if (sc == 1)      q = '{8'hFF, 8'h05};
                else if (sc == 4) q = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAB};
                else              q = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
            end
            6'd55: q = '{8'hFF, 8'h01};
            6'd41: begin
                if (sc == 1)                   q = '{8'hFF, 8'h00};
                else if (sc == 3 || n_acmd < 3) q = '{8'hFF, 8'h01};
                else                            q = '{8'hFF, 8'h00};
            end
            6'd58: q = '{8'hFF, 8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00};
            default: q.delete();
        endcase
    endtask

    always @(posedge clk) begin
        #1;
        xfer_done_i = 1'b0;
        if (!rst_n) begin
            if (xfer_start_o) rst_starts++;
            fcnt = 0;
            q.delete();
        end else if (xfer_start_o) begin
            nbytes++;
            xfer_rx_i = 8'hFF;
            if (cs_o) begin
                if (!seen_cs0) npwr++;
                fcnt = 0;
                q.delete();
            end else begin
                seen_cs0 = 1'b1;
                if (fcnt > 0) begin
                    if (fcnt == 1 && mcmd == 6'd41 && n_acmd == 1)
                        acmd_arg = xfer_tx_o;
                    fcnt++;
                    if (fcnt == 6) begin
                        fcnt = 0;
                        load(mcmd);
                    end
                end else if (q.size() > 0) begin
                    xfer_rx_i = q.pop_front();
                    npop++;
                    if (mcmd == 6'd8 && npop >= 3) tail8 = 1'b1;
                end else if (xfer_tx_o[7:6] == 2'b01) begin
                    mcmd = xfer_tx_o[5:0];
                    fcnt = 1;
                    npop = 0;
                    if (mcmd == 6'd41) n_acmd++;
                end
            end
            xfer_done_i = 1'b1;
        end
    end

    task automatic clear_model(input int s);
        sc = s;
        nbytes = 0;
        npwr = 0;
        fcnt = 0;
        npop = 0;
        n_acmd = 0;
        seen_cs0 = 1'b0;
        tail8 = 1'b0;
        mcmd = 6'h3F;
        acmd_arg = 8'hEE;
        q.delete();
    endtask

    task automatic kick(input string tag);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, "_first_start"}, 32'(xfer_start_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        chk({tag, "_flags_clr"},
            32'({ready_o, err_o, err_code_o, card_v2_o, card_hc_o}), 32'd0);
        chk({tag, "_stat_slow"}, 32'(spi_statusreg_o), 32'h27);
    endtask

    task automatic run(input int s, input string tag);
        int i;
        clear_model(s);
        kick(tag);
        for (i = 0; i < 40000 && !(ready_o || err_o); i++) @(negedge clk);
        chk({tag, "_finished"}, 32'(ready_o | err_o), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy_o), 32'd0);
        chk({tag, "_cs_end"}, 32'(cs_o), 32'd1);
    endtask

    initial begin
        clear_model(0);
        rst_starts = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_flags", 32'({ready_o, err_o, err_code_o, card_v2_o, card_hc_o}), 32'd0);
        chk("rst_cs", 32'(cs_o), 32'd1);
        chk("rst_xstart", 32'(xfer_start_o), 32'd0);
        chk("rst_tx", 32'(xfer_tx_o), 32'hFF);
        chk("rst_stat", 32'(spi_statusreg_o), 32'h26);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // SDHC v2 card
        run(0, "hc");
        chk("hc_ready", 32'(ready_o), 32'd1);
        chk("hc_err", 32'(err_o), 32'd0);
        chk("hc_v2", 32'(card_v2_o), 32'd1);
        chk("hc_hc", 32'(card_hc_o), 32'd1);
        chk("hc_acmd_n", 32'(n_acmd), 32'd3);
        chk("hc_acmd_arg", 32'(acmd_arg), 32'h40);
        chk("hc_pwr", 32'(npwr), 32'd10);
        chk("hc_stat_fast", 32'(spi_statusreg_o), 32'h06);

        // v1 card
        run(1, "v1");
        chk("v1_ready", 32'(ready_o), 32'd1);
        chk("v1_v2", 32'(card_v2_o), 32'd0);
        chk("v1_hc", 32'(card_hc_o), 32'd0);
        chk("v1_acmd_arg", 32'(acmd_arg), 32'h00);

        // silent card
        run(2, "sil");
        chk("sil_err", 32'(err_o), 32'd1);
        chk("sil_code", 32'(err_code_o), 32'd5);
        chk("sil_bytes", 32'(nbytes), 32'd24);
        chk("sil_stat", 32'(spi_statusreg_o), 32'h26);

        // ACMD41 never leaves idle
        run(3, "to");
        chk("to_code", 32'(err_code_o), 32'd3);
        chk("to_acmd_n", 32'(n_acmd), 32'd1000);
        chk("to_ready", 32'(ready_o), 32'd0);

        // bad CMD8 echo
        run(4, "echo");
        chk("echo_code", 32'(err_code_o), 32'd2);
        chk("echo_v2", 32'(card_v2_o), 32'd0);

        // reset during the CMD8 tail, then restart
        clear_model(5);
        kick("mid");
        for (int i = 0; i < 200 && !tail8; i++) @(negedge clk);
        chk("mid_tail_reached", 32'(tail8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_cs", 32'(cs_o), 32'd1);
        chk("mid_stat", 32'(spi_statusreg_o), 32'h26);
        chk("mid_xstart", 32'(xfer_start_o), 32'd0);
        chk("mid_flags", 32'({busy_o, ready_o, err_o, err_code_o, card_v2_o, card_hc_o}), 32'd0);
        rst_starts = 0;
        repeat (4) @(negedge clk);
        chk("mid_no_start", 32'(rst_starts), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run(5, "rs");
        chk("rs_pwr", 32'(npwr), 32'd10);
        chk("rs_ready", 32'(ready_o), 32'd1);
        chk("rs_hc", 32'(card_hc_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
